// File: rtl/gpio_sig_pkg.sv
// Shared types and constants for the GPIO signature monitor.
package gpio_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // CRC-32 polynomial used as the default MISR feedback
    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

endpackage

// File: rtl/gpio_sig_misr.sv
// Multiple-input signature register: folds a WIDTH-bit sample into SIG_W bits
// and combines it with a shift/polynomial-feedback register.
module gpio_sig_misr
    import gpio_sig_pkg::*;
#(
    parameter int               WIDTH = 34,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [SIG_W-1:0] sig
);

    localparam int N_CHUNK = (WIDTH + SIG_W - 1) / SIG_W;
    localparam int PAD_W   = N_CHUNK * SIG_W;

    logic [SIG_W-1:0] sig_r;
    logic [SIG_W-1:0] fold_s;
    logic [SIG_W-1:0] fb_s;
    logic [SIG_W-1:0] sig_nx_s;

    // XOR of SIG_W-bit chunks; the top chunk is zero-padded
    function automatic logic [SIG_W-1:0] fold(input logic [WIDTH-1:0] d);
        logic [PAD_W-1:0] padded;
        logic [SIG_W-1:0] acc;
        padded = PAD_W'(d);
        acc    = {SIG_W{1'b0}};
        for (int i = 0; i < N_CHUNK; i++) begin
            acc = acc ^ padded[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // Next signature value
    always_comb begin
        fold_s   = fold(data);
        fb_s     = sig_r[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        sig_nx_s = {sig_r[SIG_W-2:0], 1'b0} ^ fb_s ^ fold_s;
    end

    // Signature register: seed load has priority over update
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sig_r <= {SIG_W{1'b0}};
        end else if (load) begin
            sig_r <= seed;
        end else if (en) begin
            sig_r <= sig_nx_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/gpio_sig_monitor.sv
// GPIO signature monitor: synchronises a bank of pad-facing signals, compresses
// masked activity into a MISR signature and reports pass, fail or timeout.
module gpio_sig_monitor
    import gpio_sig_pkg::*;
#(
    parameter int               WIDTH       = 34,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEFAULT_POLY),
    parameter int               CNT_W       = 16,
    parameter int               TMO_W       = 24,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] mon_in,
    input  logic [WIDTH-1:0] mask,
    input  logic             start,
    input  logic             mode,
    input  logic [SIG_W-1:0] seed,
    input  logic [CNT_W-1:0] exp_events,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] event_cnt
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] samp_s;
    logic [WIDTH-1:0] arm_samp_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] mask_r;
    logic             mode_r;
    logic [CNT_W-1:0] exp_ev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [SIG_W-1:0] exp_sig_r;
    logic [SIG_W-1:0] sig_s;
    logic [TMO_W-1:0] tmo_r;
    logic [TMO_W-1:0] wdog_r;
    logic             evt_s;
    logic             reached_s;
    logic             last_evt_s;
    logic             expire_s;
    logic             upd_s;
    state_e           state_r;
    state_e           state_nx;
    logic             busy_r, done_r, pass_r, fail_r, tmo_flag_r;
    logic             busy_nx, done_nx, pass_nx, fail_nx, tmo_nx;

    // Input synchroniser chain; everything downstream sees only the last stage
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= mon_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Event, completion and watchdog qualifiers
    always_comb begin
        sync_s     = sync_r[SYNC_STAGES-1];
        samp_s     = sync_s & mask_r;
        arm_samp_s = sync_s & mask;
        evt_s      = mode_r || (samp_s != prev_r);
        reached_s  = (cnt_r == exp_ev_r);
        cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        last_evt_s = (cnt_inc_s == exp_ev_r);
        expire_s   = (tmo_r != {TMO_W{1'b0}}) && (wdog_r == tmo_r - TMO_W'(1));
        upd_s      = !start && (state_r == ST_RUN) && !reached_s && evt_s;
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next state; a final event beats a simultaneous watchdog expiry
    always_comb begin
        state_nx = state_r;
        if (start) begin
            state_nx = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: state_nx = ST_IDLE;
                ST_RUN: begin
                    if (reached_s) begin
                        state_nx = ST_CMP;
                    end else if (evt_s && last_evt_s) begin
                        state_nx = ST_CMP;
                    end else if (expire_s) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                ST_CMP:  state_nx = ST_DONE;
                ST_DONE: state_nx = ST_DONE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM output decode (next values of the status registers)
    always_comb begin
        busy_nx = (state_nx == ST_RUN) || (state_nx == ST_CMP);
        done_nx = done_r;
        pass_nx = pass_r;
        fail_nx = fail_r;
        tmo_nx  = tmo_flag_r;
        if (start) begin
            done_nx = 1'b0;
            pass_nx = 1'b0;
            fail_nx = 1'b0;
            tmo_nx  = 1'b0;
        end else if (state_r == ST_CMP) begin
            done_nx = 1'b1;
            pass_nx = (sig_s == exp_sig_r);
            fail_nx = (sig_s != exp_sig_r);
            tmo_nx  = 1'b0;
        end else if ((state_r == ST_RUN) && (state_nx == ST_DONE)) begin
            tmo_nx  = 1'b1;
        end else begin
            done_nx = done_r;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
            tmo_flag_r <= 1'b0;
        end else begin
            busy_r     <= busy_nx;
            done_r     <= done_nx;
            pass_r     <= pass_nx;
            fail_r     <= fail_nx;
            tmo_flag_r <= tmo_nx;
        end
    end

    // Run context: configuration latched at start, previous sample, counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mask_r    <= {WIDTH{1'b0}};
            mode_r    <= 1'b0;
            exp_ev_r  <= {CNT_W{1'b0}};
            exp_sig_r <= {SIG_W{1'b0}};
            tmo_r     <= {TMO_W{1'b0}};
            prev_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            wdog_r    <= {TMO_W{1'b0}};
        end else if (start) begin
            mask_r    <= mask;
            mode_r    <= mode;
            exp_ev_r  <= exp_events;
            exp_sig_r <= exp_sig;
            tmo_r     <= tmo_limit;
            prev_r    <= arm_samp_s;
            cnt_r     <= {CNT_W{1'b0}};
            wdog_r    <= {TMO_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            if (tmo_r != {TMO_W{1'b0}}) begin
                wdog_r <= wdog_r + TMO_W'(1);
            end else begin
                wdog_r <= wdog_r;
            end
            if (upd_s) begin
                prev_r <= samp_s;
                cnt_r  <= cnt_inc_s;
            end else begin
                prev_r <= prev_r;
                cnt_r  <= cnt_r;
            end
        end else begin
            wdog_r <= wdog_r;
            prev_r <= prev_r;
            cnt_r  <= cnt_r;
        end
    end

    gpio_sig_misr #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk  (clk),
        .nrst (nrst),
        .load (start),
        .seed (seed),
        .en   (upd_s),
        .data (samp_s),
        .sig  (sig_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign timeout   = tmo_flag_r;
    assign signature = sig_s;
    assign event_cnt = cnt_r;

endmodule

// File: tb/tb_gpio_sig_monitor.sv
// Directed bench for gpio_sig_monitor (8-bit bank, 8-bit signature, POLY 8'h1D).
module tb_gpio_sig_monitor;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  mon_in, mask, seed, exp_sig;
    logic        start, mode;
    logic [15:0] exp_events;
    logic [23:0] tmo_limit;
    logic        busy, done, pass, fail, timeout;
    logic [7:0]  signature;
    logic [15:0] event_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    gpio_sig_monitor #(
        .WIDTH(8), .SIG_W(8), .POLY(8'h1D), .CNT_W(16), .TMO_W(24), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .nrst(nrst), .mon_in(mon_in), .mask(mask), .start(start),
        .mode(mode), .seed(seed), .exp_events(exp_events), .exp_sig(exp_sig),
        .tmo_limit(tmo_limit), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .signature(signature), .event_cnt(event_cnt)
    );

    // flags are {busy, done, pass, fail, timeout}
    localparam logic [4:0] FZ = 5'b00000;
    localparam logic [4:0] FB = 5'b10000;
    localparam logic [4:0] FP = 5'b01100;
    localparam logic [4:0] FF = 5'b01010;
    localparam logic [4:0] FT = 5'b00001;

    typedef struct {
        int          scen;
        logic        arm;
        logic [7:0]  mask;
        logic        mode;
        logic [7:0]  seed;
        logic [15:0] exp_ev;
        logic [7:0]  exp_sig;
        logic [23:0] tmo;
        logic [7:0]  mon;
        logic [7:0]  e_sig;
        logic [15:0] e_cnt;
        logic [4:0]  e_fl;
    } vec_t;

    vec_t tbl[$];
    int          c_scen;
    logic [7:0]  c_mask, c_seed, c_exp_sig;
    logic        c_mode;
    logic [15:0] c_exp_ev;
    logic [23:0] c_tmo;

    function automatic void cfg(int sc, logic [7:0] m, logic md, logic [7:0] sd,
                                logic [15:0] ee, logic [7:0] es, logic [23:0] t);
        c_scen = sc; c_mask = m; c_mode = md; c_seed = sd;
        c_exp_ev = ee; c_exp_sig = es; c_tmo = t;
    endfunction

    function automatic void row(logic arm, logic [7:0] mon, logic [7:0] es,
                                logic [15:0] ec, logic [4:0] fl);
        vec_t v;
        v.scen = c_scen; v.arm = arm; v.mask = c_mask; v.mode = c_mode;
        v.seed = c_seed; v.exp_ev = c_exp_ev; v.exp_sig = c_exp_sig; v.tmo = c_tmo;
        v.mon = mon; v.e_sig = es; v.e_cnt = ec; v.e_fl = fl;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: three changes, matching signature
        cfg(1, 8'hFF, 1'b0, 8'h00, 16'd3, 8'h82, 24'd0);
        row(1'b1, 8'h01, 8'h00, 16'd0, FB); row(1'b0, 8'h03, 8'h00, 16'd0, FB);
        row(1'b0, 8'h80, 8'h01, 16'd1, FB); row(1'b0, 8'h80, 8'h01, 16'd2, FB);
        row(1'b0, 8'h80, 8'h82, 16'd3, FB); row(1'b0, 8'h80, 8'h82, 16'd3, FP);
        row(1'b0, 8'h00, 8'h82, 16'd3, FP); row(1'b0, 8'h00, 8'h82, 16'd3, FP);
        // 2: same stimulus, wrong expected signature
        cfg(2, 8'hFF, 1'b0, 8'h00, 16'd3, 8'h83, 24'd0);
        row(1'b1, 8'h01, 8'h00, 16'd0, FB); row(1'b0, 8'h03, 8'h00, 16'd0, FB);
        row(1'b0, 8'h80, 8'h01, 16'd1, FB); row(1'b0, 8'h80, 8'h01, 16'd2, FB);
        row(1'b0, 8'h80, 8'h82, 16'd3, FB); row(1'b0, 8'h80, 8'h82, 16'd3, FF);
        row(1'b0, 8'h00, 8'h82, 16'd3, FF); row(1'b0, 8'h00, 8'h82, 16'd3, FF);
        // 3: fourth change exercises the polynomial feedback
        cfg(3, 8'hFF, 1'b0, 8'h00, 16'd4, 8'h19, 24'd0);
        row(1'b1, 8'h01, 8'h00, 16'd0, FB); row(1'b0, 8'h03, 8'h00, 16'd0, FB);
        row(1'b0, 8'h80, 8'h01, 16'd1, FB); row(1'b0, 8'h00, 8'h01, 16'd2, FB);
        row(1'b0, 8'h00, 8'h82, 16'd3, FB); row(1'b0, 8'h00, 8'h19, 16'd4, FB);
        row(1'b0, 8'h00, 8'h19, 16'd4, FP);
        // 5: mode 1, masked-out toggling bit folds in as zero
        cfg(5, 8'h0F, 1'b1, 8'h00, 16'd5, 8'h00, 24'd0);
        row(1'b1, 8'h80, 8'h00, 16'd0, FB); row(1'b0, 8'h00, 8'h00, 16'd1, FB);
        row(1'b0, 8'h80, 8'h00, 16'd2, FB); row(1'b0, 8'h00, 8'h00, 16'd3, FB);
        row(1'b0, 8'h80, 8'h00, 16'd4, FB); row(1'b0, 8'h00, 8'h00, 16'd5, FB);
        row(1'b0, 8'h00, 8'h00, 16'd5, FP); row(1'b0, 8'h00, 8'h00, 16'd5, FP);
        // 7: exp_events == 0 compares the seed straight away
        cfg(7, 8'hFF, 1'b0, 8'h5A, 16'd0, 8'h5A, 24'd0);
        row(1'b1, 8'h00, 8'h5A, 16'd0, FB); row(1'b0, 8'h00, 8'h5A, 16'd0, FB);
        row(1'b0, 8'h00, 8'h5A, 16'd0, FP);
        // 4a: static input, watchdog of 10 cycles
        cfg(4, 8'hFF, 1'b0, 8'h00, 16'd3, 8'h82, 24'd10);
        row(1'b1, 8'h00, 8'h00, 16'd0, FB);
        for (int k = 1; k <= 9; k++) row(1'b0, 8'h00, 8'h00, 16'd0, FB);
        row(1'b0, 8'h00, 8'h00, 16'd0, FT); row(1'b0, 8'h00, 8'h00, 16'd0, FT);
        // 4b: final event on the expiry cycle wins
        cfg(8, 8'hFF, 1'b0, 8'h00, 16'd1, 8'h01, 24'd2);
        row(1'b1, 8'h01, 8'h00, 16'd0, FB); row(1'b0, 8'h01, 8'h00, 16'd0, FB);
        row(1'b0, 8'h01, 8'h01, 16'd1, FB); row(1'b0, 8'h01, 8'h01, 16'd1, FP);
        row(1'b0, 8'h00, 8'h01, 16'd1, FP); row(1'b0, 8'h00, 8'h01, 16'd1, FP);
        // 6a: re-arm after two events, second run completes on its own terms
        cfg(6, 8'hFF, 1'b0, 8'h00, 16'd3, 8'h82, 24'd0);
        row(1'b1, 8'h01, 8'h00, 16'd0, FB); row(1'b0, 8'h03, 8'h00, 16'd0, FB);
        row(1'b0, 8'h03, 8'h01, 16'd1, FB); row(1'b0, 8'h03, 8'h01, 16'd2, FB);
        cfg(9, 8'hFF, 1'b0, 8'h33, 16'd1, 8'h61, 24'd0);
        row(1'b1, 8'h03, 8'h33, 16'd0, FB); row(1'b0, 8'h03, 8'h33, 16'd0, FB);
        row(1'b0, 8'h07, 8'h33, 16'd0, FB); row(1'b0, 8'h07, 8'h33, 16'd0, FB);
        row(1'b0, 8'h07, 8'h61, 16'd1, FB); row(1'b0, 8'h07, 8'h61, 16'd1, FP);

        nrst = 1'b0; start = 1'b0; mode = 1'b0; mon_in = 8'h00; mask = 8'h00;
        seed = 8'h00; exp_events = 16'd0; exp_sig = 8'h00; tmo_limit = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {27'd0, busy, done, pass, fail, timeout}, 32'(FZ));
        check("reset_sig", 32'(signature), 32'h0);
        check("reset_cnt", 32'(event_cnt), 32'h0);
        nrst = 1'b1;
        tick(); tick();

        // Non-arm rows drive inverted configuration, which must be ignored
        for (int i = 0; i < tbl.size(); i++) begin
            start  = tbl[i].arm;
            mon_in = tbl[i].mon;
            if (tbl[i].arm) begin
                mask = tbl[i].mask; mode = tbl[i].mode; seed = tbl[i].seed;
                exp_events = tbl[i].exp_ev; exp_sig = tbl[i].exp_sig; tmo_limit = tbl[i].tmo;
            end else begin
                mask = ~tbl[i].mask; mode = ~tbl[i].mode; seed = ~tbl[i].seed;
                exp_events = ~tbl[i].exp_ev; exp_sig = ~tbl[i].exp_sig; tmo_limit = ~tbl[i].tmo;
            end
            tick();
            check($sformatf("s%0d_row%0d_sig", tbl[i].scen, i), 32'(signature), 32'(tbl[i].e_sig));
            check($sformatf("s%0d_row%0d_cnt", tbl[i].scen, i), 32'(event_cnt), 32'(tbl[i].e_cnt));
            check($sformatf("s%0d_row%0d_flags", tbl[i].scen, i),
                  {27'd0, busy, done, pass, fail, timeout}, 32'(tbl[i].e_fl));
        end
        start = 1'b0;

        // 6b: asynchronous reset in the middle of a run
        mon_in = 8'h00;
        tick(); tick();
        start = 1'b1; mask = 8'hFF; mode = 1'b0; seed = 8'hA5;
        exp_events = 16'd3; exp_sig = 8'h00; tmo_limit = 24'd0;
        tick();
        start = 1'b0; mon_in = 8'h01;
        repeat (4) tick();
        check("midrun_sig", 32'(signature), 32'h56);
        check("midrun_cnt", 32'(event_cnt), 32'd1);
        check("midrun_busy", 32'(busy), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_flags", {27'd0, busy, done, pass, fail, timeout}, 32'(FZ));
        check("async_rst_sig", 32'(signature), 32'h0);
        check("async_rst_cnt", 32'(event_cnt), 32'h0);
        tick();
        nrst = 1'b1;
        repeat (5) tick();
        check("post_rst_flags", {27'd0, busy, done, pass, fail, timeout}, 32'(FZ));
        check("post_rst_sig", 32'(signature), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
